// File: rtl/i2c_bus_arbiter.sv
// Round-robin I2C bus arbiter for N_REQ on-chip masters with START/STOP detection and bus-free qualification.
// Define GRANT_WATCHDOG_EN to build in the grant watchdog that revokes a stalled owner after TIMEOUT_CYCLES.
module i2c_bus_arbiter #(
   parameter int unsigned N_REQ           = 2,
   parameter int unsigned BUS_FREE_CYCLES = 16,
   parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             scl_in,
   input  logic             sda_in,
   input  logic             scl_rise,
   input  logic             scl_fall,
   input  logic             sda_rise,
   input  logic             sda_fall,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] done,
   output logic [N_REQ-1:0] grant,
   output logic             bus_busy,
   output logic             start_det,
   output logic             stop_det,
   output logic             timeout
);

   localparam int unsigned PW = $clog2(N_REQ);
   localparam int unsigned CW = $clog2(BUS_FREE_CYCLES);
   localparam logic [CW-1:0]    CNT_LAST  = CW'(BUS_FREE_CYCLES - 1);
   localparam logic [N_REQ-1:0] GRANT_ONE = N_REQ'(1);

   if (N_REQ < 2 || N_REQ > 4 || BUS_FREE_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("i2c_bus_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {WAIT_FREE, IDLE, GRANT, BUSY_EXT} state_t;

   state_t          state;
   logic [CW-1:0]   idle_cnt;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   rr_win;
   logic [PW-1:0]   cand;
   int unsigned     idx;
   logic            start_c;
   logic            stop_c;
   logic            line_clean;
   logic            owner_release;

   assign start_c       = sda_fall & scl_in;
   assign stop_c        = sda_rise & scl_in;
   assign line_clean    = scl_in & sda_in & ~(scl_rise | scl_fall | sda_rise | sda_fall);
   assign owner_release = (|(grant & done)) | ~(|(grant & req)) | stop_c;

   // Scan downward so the candidate closest above rr_ptr is the last one written.
   always_comb begin
      rr_win = rr_ptr;
      cand   = '0;
      idx    = 0;
      for (int unsigned i = N_REQ; i >= 1; i--) begin
         idx = 32'(rr_ptr) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         cand = PW'(idx);
         if (req[cand]) rr_win = cand;
      end
   end

`ifdef GRANT_WATCHDOG_EN
   localparam int unsigned WW = $clog2(TIMEOUT_CYCLES);
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
   logic [WW-1:0] wd_cnt;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= WAIT_FREE;
         idle_cnt  <= '0;
         rr_ptr    <= PW'(N_REQ - 1);
         grant     <= '0;
         bus_busy  <= 1'b1;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
`ifdef GRANT_WATCHDOG_EN
         wd_cnt    <= '0;
         timeout   <= 1'b0;
`endif
      end else begin
         start_det <= start_c;
         stop_det  <= stop_c;
`ifdef GRANT_WATCHDOG_EN
         timeout   <= 1'b0;
`endif
         case (state)
            WAIT_FREE: begin
               if (start_c) begin
                  state    <= BUSY_EXT;
                  idle_cnt <= '0;
               end else if (!line_clean) begin
                  idle_cnt <= '0;
               end else if (idle_cnt == CNT_LAST) begin
                  state    <= IDLE;
                  bus_busy <= 1'b0;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            IDLE: begin
               if (start_c) begin
                  state    <= BUSY_EXT;
                  bus_busy <= 1'b1;
               end else if (|req) begin
                  state    <= GRANT;
                  bus_busy <= 1'b1;
                  grant    <= GRANT_ONE << rr_win;
                  rr_ptr   <= rr_win;
`ifdef GRANT_WATCHDOG_EN
                  wd_cnt   <= '0;
`endif
               end
            end
            GRANT: begin
               if (owner_release) begin
                  state    <= WAIT_FREE;
                  grant    <= '0;
                  idle_cnt <= '0;
               end
`ifdef GRANT_WATCHDOG_EN
               else if (scl_rise | scl_fall) begin
                  wd_cnt <= '0;
               end else if (wd_cnt == WD_LAST) begin
                  state    <= WAIT_FREE;
                  grant    <= '0;
                  idle_cnt <= '0;
                  timeout  <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
`endif
            end
            BUSY_EXT: begin
               if (stop_c) begin
                  state    <= WAIT_FREE;
                  idle_cnt <= '0;
               end
            end
            default: begin
               state <= WAIT_FREE;
               grant <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed, table-driven bench for i2c_bus_arbiter (N_REQ=2, BUS_FREE_CYCLES=16).
// Watchdog sequence is included when GRANT_WATCHDOG_EN is defined (TIMEOUT_CYCLES=32).
module tb_i2c_bus_arbiter;

   localparam int unsigned N = 2;

   // Line encodings: {scl_in, sda_in, scl_rise, scl_fall, sda_rise, sda_fall}
   localparam logic [5:0] H    = 6'b110000;
   localparam logic [5:0] STA  = 6'b100001;
   localparam logic [5:0] SDL  = 6'b100000;
   localparam logic [5:0] STO  = 6'b110010;
   localparam logic [5:0] SCLF = 6'b010100;
   localparam logic [5:0] SCLR = 6'b111000;
   localparam logic [5:0] F0   = 6'b000100;
   localparam logic [5:0] DR0  = 6'b010010;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         scl_in, sda_in, scl_rise, scl_fall, sda_rise, sda_fall;
   logic [N-1:0] req, done, grant;
   logic         bus_busy, start_det, stop_det, timeout;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      string       name;
      int unsigned n;
      logic [5:0]  ln;
      logic [1:0]  rq;
      logic [1:0]  dn;
      logic [1:0]  eg;
      logic        eb;
      logic        esd;
      logic        epd;
   } vec_t;

   vec_t tbl[$];

   i2c_bus_arbiter #(
      .N_REQ(N),
      .BUS_FREE_CYCLES(16),
      .TIMEOUT_CYCLES(32)
   ) dut (
      .clk(clk), .rst(rst),
      .scl_in(scl_in), .sda_in(sda_in),
      .scl_rise(scl_rise), .scl_fall(scl_fall),
      .sda_rise(sda_rise), .sda_fall(sda_fall),
      .req(req), .done(done),
      .grant(grant), .bus_busy(bus_busy),
      .start_det(start_det), .stop_det(stop_det), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic add(input string nm, input int unsigned n, input logic [5:0] ln,
                      input logic [1:0] rq, input logic [1:0] dn, input logic [1:0] eg,
                      input logic eb, input logic esd, input logic epd);
      vec_t v;
      v.name = nm; v.n = n; v.ln = ln; v.rq = rq; v.dn = dn;
      v.eg = eg; v.eb = eb; v.esd = esd; v.epd = epd;
      tbl.push_back(v);
   endtask

   task automatic apply(input int unsigned n, input logic [5:0] ln,
                        input logic [1:0] rq, input logic [1:0] dn);
      for (int unsigned c = 0; c < n; c++) begin
         {scl_in, sda_in, scl_rise, scl_fall, sda_rise, sda_fall} = ln;
         req  = rq;
         done = dn;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string nm, input logic [1:0] eg, input logic eb,
                        input logic esd, input logic epd, input logic eto);
      n_vec++;
      if (grant !== eg || bus_busy !== eb || start_det !== esd ||
          stop_det !== epd || timeout !== eto) begin
         n_bad++;
         $display("FAIL %s: got grant=%b busy=%b start_det=%b stop_det=%b timeout=%b, expected grant=%b busy=%b start_det=%b stop_det=%b timeout=%b",
                  nm, grant, bus_busy, start_det, stop_det, timeout, eg, eb, esd, epd, eto);
      end
   endtask

   initial begin
      //   name               n   lines req    done   grant  busy sd pd
      add("wf_after_reset",  15, H,    2'b00, 2'b00, 2'b00, 1, 0, 0);
      add("idle_at_16",       1, H,    2'b00, 2'b00, 2'b00, 0, 0, 0);
      add("grant_e0",         1, H,    2'b11, 2'b00, 2'b01, 1, 0, 0);
      add("hold_e0",          4, H,    2'b11, 2'b00, 2'b01, 1, 0, 0);
      add("done_e0",          1, H,    2'b11, 2'b01, 2'b00, 1, 0, 0);
      add("wf_after_e0",     15, H,    2'b11, 2'b00, 2'b00, 1, 0, 0);
      add("idle_after_e0",    1, H,    2'b11, 2'b00, 2'b00, 0, 0, 0);
      add("grant_e1",         1, H,    2'b11, 2'b00, 2'b10, 1, 0, 0);
      add("foreign_done",     1, H,    2'b11, 2'b01, 2'b10, 1, 0, 0);
      add("hold_e1",          3, H,    2'b11, 2'b00, 2'b10, 1, 0, 0);
      add("done_e1",          1, H,    2'b11, 2'b10, 2'b00, 1, 0, 0);
      add("wf_after_e1",     15, H,    2'b11, 2'b00, 2'b00, 1, 0, 0);
      add("idle_after_e1",    1, H,    2'b11, 2'b00, 2'b00, 0, 0, 0);
      add("grant_e0_again",   1, H,    2'b11, 2'b00, 2'b01, 1, 0, 0);
      add("owner_start",      1, STA,  2'b11, 2'b00, 2'b01, 1, 1, 0);
      add("owner_sda_low",    1, SDL,  2'b11, 2'b00, 2'b01, 1, 0, 0);
      add("owner_stop",       1, STO,  2'b11, 2'b00, 2'b00, 1, 0, 1);
      add("wf_after_stop",   15, H,    2'b00, 2'b00, 2'b00, 1, 0, 0);
      add("idle_after_stop",  1, H,    2'b00, 2'b00, 2'b00, 0, 0, 0);
      add("ext_start_vs_req", 1, STA,  2'b01, 2'b00, 2'b00, 1, 1, 0);
      add("ext_hold",         5, SDL,  2'b01, 2'b00, 2'b00, 1, 0, 0);
      add("ext_scl_fall",     1, F0,   2'b01, 2'b00, 2'b00, 1, 0, 0);
      add("ext_sda_rise_lo",  1, DR0,  2'b01, 2'b00, 2'b00, 1, 0, 0);
      add("ext_scl_rise",     1, SCLR, 2'b01, 2'b00, 2'b00, 1, 0, 0);
      add("ext_rep_start",    1, STA,  2'b01, 2'b00, 2'b00, 1, 1, 0);
      add("ext_stop",         1, STO,  2'b01, 2'b00, 2'b00, 1, 0, 1);
      add("wf_after_ext",    15, H,    2'b01, 2'b00, 2'b00, 1, 0, 0);
      add("idle_after_ext",   1, H,    2'b01, 2'b00, 2'b00, 0, 0, 0);
      add("grant_single",     1, H,    2'b01, 2'b00, 2'b01, 1, 0, 0);
      add("done_and_stop",    1, STO,  2'b01, 2'b01, 2'b00, 1, 0, 1);
      add("wf_cnt10",        10, H,    2'b00, 2'b00, 2'b00, 1, 0, 0);
      add("wf_scl_fall",      1, SCLF, 2'b00, 2'b00, 2'b00, 1, 0, 0);
      add("wf_scl_rise",      1, SCLR, 2'b00, 2'b00, 2'b00, 1, 0, 0);
      add("wf_restart_15",   15, H,    2'b00, 2'b00, 2'b00, 1, 0, 0);
      add("wf_restart_16",    1, H,    2'b00, 2'b00, 2'b00, 0, 0, 0);
      add("grant_e1_only",    1, H,    2'b10, 2'b00, 2'b10, 1, 0, 0);
      add("hold_e1_only",     2, H,    2'b10, 2'b00, 2'b10, 1, 0, 0);
      add("owner_req_drop",   1, H,    2'b00, 2'b00, 2'b00, 1, 0, 0);
      add("wf_to_limit",     15, H,    2'b00, 2'b00, 2'b00, 1, 0, 0);
      add("edge_at_limit",    1, SCLR, 2'b00, 2'b00, 2'b00, 1, 0, 0);
      add("wf_after_limit",  15, H,    2'b00, 2'b00, 2'b00, 1, 0, 0);
      add("idle_after_limit", 1, H,    2'b00, 2'b00, 2'b00, 0, 0, 0);
      add("grant_rr_e0",      1, H,    2'b11, 2'b00, 2'b01, 1, 0, 0);
      add("nonowner_req_drop",1, H,    2'b01, 2'b00, 2'b01, 1, 0, 0);

      {scl_in, sda_in, scl_rise, scl_fall, sda_rise, sda_fall} = H;
      req  = '0;
      done = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", 2'b00, 1, 0, 0, 0);
      #1 rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i].n, tbl[i].ln, tbl[i].rq, tbl[i].dn);
         check(tbl[i].name, tbl[i].eg, tbl[i].eb, tbl[i].esd, tbl[i].epd, 1'b0);
      end

      // Asynchronous reset while engine 0 holds the bus
      #3 rst = 1'b1;
      #1 check("async_rst_mid_grant", 2'b00, 1, 0, 0, 0);
      @(posedge clk);
      #2 rst = 1'b0;

      apply(15, H, 2'b00, 2'b00);
      check("post_rst_wf", 2'b00, 1, 0, 0, 0);
      apply(1, H, 2'b00, 2'b00);
      check("post_rst_idle", 2'b00, 0, 0, 0, 0);
      apply(1, H, 2'b01, 2'b00);
      check("post_rst_grant_e0", 2'b01, 1, 0, 0, 0);

`ifdef GRANT_WATCHDOG_EN
      apply(31, H, 2'b11, 2'b00);
      check("wd_before_limit", 2'b01, 1, 0, 0, 0);
      apply(1, H, 2'b11, 2'b00);
      check("wd_revoke", 2'b00, 1, 0, 0, 1);
      apply(15, H, 2'b11, 2'b00);
      check("wd_wf", 2'b00, 1, 0, 0, 0);
      apply(1, H, 2'b11, 2'b00);
      check("wd_idle", 2'b00, 0, 0, 0, 0);
      apply(1, H, 2'b11, 2'b00);
      check("wd_next_e1", 2'b10, 1, 0, 0, 0);
`else
      apply(40, H, 2'b01, 2'b00);
      check("stalled_owner_holds", 2'b01, 1, 0, 0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares the I2C bus between N_REQ on-chip master engines.
- Consumes the single-cycle SCL/SDA edge pulses produced by the transition detectors, plus the synchronized line levels.
- Detects START/STOP, tracks bus-free time and grants ownership round-robin.
- Foreign masters are respected: no grant is issued while a START from another master is outstanding.

Parameters:
- N_REQ, 2, number of requesting master engines (2..4).
- BUS_FREE_CYCLES, 16, consecutive idle clk cycles (SCL=SDA=1, no edges) required before the bus is considered free.
- TIMEOUT_CYCLES, 1024, grant watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- scl_in  in  1  synchronized SCL level
- sda_in  in  1  synchronized SDA level
- scl_rise  in  1  one-cycle pulse, SCL low->high
- scl_fall  in  1  one-cycle pulse, SCL high->low
- sda_rise  in  1  one-cycle pulse, SDA low->high
- sda_fall  in  1  one-cycle pulse, SDA high->low
- req  in  N_REQ  level request per engine
- done  in  N_REQ  one-cycle release pulse per engine
- grant  out  N_REQ  one-hot ownership, registered
- bus_busy  out  1  registered; 0 only in IDLE
- start_det  out  1  registered pulse, START seen
- stop_det  out  1  registered pulse, STOP seen
- timeout  out  1  registered pulse, watchdog revoke (optional feature only; tied 0 otherwise)

Behaviour:
Condition decode:
- START = sda_fall & scl_in; STOP = sda_rise & scl_in.
- start_det/stop_det are asserted the cycle after the decode, 1 cycle wide.

Reset (async):
- State = WAIT_FREE; idle counter = 0; round-robin pointer = index N_REQ-1 (so engine 0 has first priority).
- grant = 0; bus_busy = 1; start_det = stop_det = timeout = 0.

State machine:
- WAIT_FREE:
  - Idle counter increments when scl_in & sda_in & no edge pulse; clears to 0 on any edge pulse or either line low.
  - Counter == BUS_FREE_CYCLES-1 -> IDLE.
  - START -> BUSY_EXT.
- IDLE (bus_busy = 0):
  - START -> BUSY_EXT. START has priority over a same-cycle req; no grant is issued.
  - Otherwise, if any req bit is set -> GRANT. grant = the first set req bit searching upward from pointer+1 with wrap. The pointer is updated to the winner.
  - Latency: req sampled at cycle n -> grant high at n+1.
- GRANT:
  - grant is held constant; START/STOP from the owner do not change state.
  - Owner's done pulse, owner's req deasserting, or STOP -> WAIT_FREE with idle counter = 0. grant drops the next cycle.
  - Simultaneous done and STOP cause a single transition.
  - done or req changes from non-owners are ignored.
- BUSY_EXT:
  - STOP -> WAIT_FREE; all req bits are ignored.
  - START (repeated start) stays in BUSY_EXT.

Invariants and boundaries:
- grant is always zero or one-hot.
- grant is never asserted outside GRANT.
- After any release, the bus must be re-qualified as free through WAIT_FREE.
- Round-robin:
  - With every req bit held high, grants rotate 0,1,..,N_REQ-1,0.
  - A single requester is re-granted after each WAIT_FREE period.
- Idle counter saturates and never wraps.
- An edge pulse on the same cycle the counter would reach its limit clears the counter; no transition occurs.
- Reset mid-grant drops grant immediately (asynchronously).

Optional Feature:
GRANT_WATCHDOG_EN
- Enabled:
  - In GRANT, a watchdog counter increments every cycle and clears on scl_rise or scl_fall.
  - Reaching TIMEOUT_CYCLES-1 -> revoke grant, pulse timeout for 1 cycle, go to WAIT_FREE.
  - The pointer still advances past the revoked owner.
- Disabled: no watchdog logic; timeout is tied 0; a stalled owner holds the bus indefinitely.

Test Plan:
- Reset then lines held high for 16 cycles -> bus_busy falls at cycle 16 after reset release; grant=00.
- In IDLE, req=11 held and each owner pulses done 5 cycles after grant -> grant sequence 01, 10, 01; each grant is separated by ≥16 idle cycles.
- In IDLE, sda_fall with scl_in=1 in the same cycle as req=01 -> start_det pulse, grant stays 00, bus_busy=1. Then sda_rise with scl_in=1 -> stop_det; grant=01 follows 16 free cycles later.
- In WAIT_FREE at counter 10, an scl_fall pulse -> counter restarts; IDLE is reached only after 16 further clean cycles.
- Granted engine 1 deasserts req while done=0 -> grant=00 next cycle, state WAIT_FREE. Assert rst mid-grant -> grant=00 immediately without a clock edge.
- With GRANT_WATCHDOG_EN and TIMEOUT_CYCLES=32, grant=01 and no SCL edges -> timeout pulse and grant=00 at cycle 32 after grant; the next grant with req=11 goes to engine 1.
